// File: rtl/uart_mux_pkg.sv
// Shared definitions for the UART<->USB mux/demux pair.
//   mux_state_t  : record-serialiser FSM encoding (IDLE=0, SEND_INDEX=1, SEND_DATA=2)
//   clog2_min1() : bits needed to hold a channel index, never less than 1
package uart_mux_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND_INDEX = 2'd1,
        SEND_DATA  = 2'd2
    } mux_state_t;

    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_in_slot.sv
// One-deep holding slot for a single UART receive channel.
//   clk, reset : clock, synchronous active-high reset
//   rx_valid   : one-cycle strobe, rx_data carries a new byte
//   rx_data    : received byte
//   take       : arbiter grants this slot this cycle (slot is freed)
//   pending    : slot holds an unsent byte
//   hold       : the held byte
//   overrun    : one-cycle pulse, a byte arrived while the slot was occupied
module uart_in_slot #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_valid,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 take,
    output logic                 pending,
    output logic [DATA_BITS-1:0] hold,
    output logic                 overrun
);

    logic                 pending_reg;
    logic                 overrun_reg;
    logic [DATA_BITS-1:0] hold_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg <= 1'b0;
            overrun_reg <= 1'b0;
            hold_reg    <= '0;
        end else begin
            // A byte is lost only when the slot stays occupied this cycle.
            overrun_reg <= rx_valid & pending_reg & ~take;
            // Capture also when the slot is being released: the arbiter has
            // already copied the old byte, so the new one takes its place.
            if (rx_valid && (!pending_reg || take)) begin
                hold_reg    <= rx_data;
                pending_reg <= 1'b1;
            end else if (take) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign pending = pending_reg;
    assign hold    = hold_reg;
    assign overrun = overrun_reg;

endmodule

// File: rtl/uart_in_mux.sv
// Merges UART_COUNT receive channels into one USB-bound FIFO as two-byte
// records: channel index, then data byte. Round-robin arbitration over the
// per-channel holding slots; a record's two bytes are always adjacent.
//   clk, reset : clock, synchronous active-high reset
//   rx_valid   : per-channel byte strobe
//   rx_data    : channel i byte at [i*DATA_BITS +: DATA_BITS]
//   fifo_full  : FIFO cannot accept a write this cycle
//   fifo_write : FIFO write enable
//   fifo_data  : FIFO write word (0 when idle)
//   overrun    : per-channel one-cycle pulse on a dropped byte
module uart_in_mux
    import uart_mux_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int UART_COUNT = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [UART_COUNT-1:0]           rx_valid,
    input  logic [UART_COUNT*DATA_BITS-1:0] rx_data,
    input  logic                            fifo_full,
    output logic                            fifo_write,
    output logic [DATA_BITS-1:0]            fifo_data,
    output logic [UART_COUNT-1:0]           overrun
);

    localparam int IDX_W = clog2_min1(UART_COUNT);

    mux_state_t           state_reg;
    logic [IDX_W-1:0]     last_reg;
    logic [IDX_W-1:0]     cur_idx_reg;
    logic [DATA_BITS-1:0] cur_data_reg;

    logic [UART_COUNT-1:0] pending;
    logic [UART_COUNT-1:0] take;
    logic [DATA_BITS-1:0]  hold [UART_COUNT];

    logic                 grant_valid;
    logic [IDX_W-1:0]     grant_idx;
    logic [DATA_BITS-1:0] grant_data;

    genvar gi;
    generate
        for (gi = 0; gi < UART_COUNT; gi++) begin : g_slot
            assign take[gi] = (state_reg == IDLE) && grant_valid &&
                              (grant_idx == IDX_W'(gi));

            uart_in_slot #(
                .DATA_BITS(DATA_BITS)
            ) u_slot (
                .clk     (clk),
                .reset   (reset),
                .rx_valid(rx_valid[gi]),
                .rx_data (rx_data[gi*DATA_BITS +: DATA_BITS]),
                .take    (take[gi]),
                .pending (pending[gi]),
                .hold    (hold[gi]),
                .overrun (overrun[gi])
            );
        end
    endgenerate

    // Round-robin search starting at last+1. Scanning from the farthest
    // candidate down to the nearest lets the nearest pending one win.
    always_comb begin
        int c;
        c           = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_data  = '0;
        for (int k = UART_COUNT; k >= 1; k--) begin
            c = (int'(last_reg) + k) % UART_COUNT;
            if (pending[c[IDX_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = c[IDX_W-1:0];
                grant_data  = hold[c[IDX_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            last_reg     <= IDX_W'(UART_COUNT - 1);
            cur_idx_reg  <= '0;
            cur_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        cur_idx_reg  <= grant_idx;
                        cur_data_reg <= grant_data;
                        last_reg     <= grant_idx;
                        state_reg    <= SEND_INDEX;
                    end
                end
                SEND_INDEX: begin
                    if (!fifo_full) state_reg <= SEND_DATA;
                end
                SEND_DATA: begin
                    if (!fifo_full) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign fifo_write = ((state_reg == SEND_INDEX) || (state_reg == SEND_DATA)) && !fifo_full;

    always_comb begin
        case (state_reg)
            SEND_INDEX: fifo_data = DATA_BITS'(cur_idx_reg);
            SEND_DATA:  fifo_data = cur_data_reg;
            default:    fifo_data = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_in_mux.sv
module tb_uart_in_mux;

    localparam int DB = 8;
    localparam int UC = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [UC-1:0]    rx_valid;
    logic [UC*DB-1:0] rx_data;
    logic             fifo_full;
    logic             fifo_write;
    logic [DB-1:0]    fifo_data;
    logic [UC-1:0]    overrun;

    uart_in_mux #(.DATA_BITS(DB), .UART_COUNT(UC)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .fifo_full (fifo_full),
        .fifo_write(fifo_write),
        .fifo_data (fifo_data),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [DB-1:0] data; int cyc; } ev_t;
    typedef struct { logic [UC-1:0] mask; int cyc; } ov_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    ov_t ov_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    // Observation side of the scoreboard, plus the never-write-while-full rule.
    always @(negedge clk) begin
        if (!reset && fifo_write) obs_q.push_back('{fifo_data, cyc});
        if (!reset && overrun != '0) ov_q.push_back('{overrun, cyc});
        if (fifo_full) begin
            tests_run++;
            if (fifo_write !== 1'b0) begin
                tests_failed++;
                $display("FAIL write_while_full: fifo_write=%0b required 0 at cycle %0d", fifo_write, cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        rx_valid  = '0;
        rx_data   = '0;
        fifo_full = 1'b0;
        tick(2);
        reset = 1'b0;
        obs_q.delete();
        exp_q.delete();
        ov_q.delete();
    endtask

    task automatic set_rx(input int ch, input logic [DB-1:0] d);
        rx_valid[ch]          = 1'b1;
        rx_data[ch*DB +: DB]  = d;
    endtask

    task automatic expect_word(input logic [DB-1:0] d, input int c);
        exp_q.push_back('{d, c});
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests_run++;
        if (fifo_write !== 1'b0 || fifo_data !== '0 || overrun !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: write=%0b data=%02h overrun=%b required 0/00/0000",
                     fifo_write, fifo_data, overrun);
        end
        tick(5);
        tests_run++;
        if (obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_idle: got %0d writes, required 0", obs_q.size());
        end
    endtask

    task automatic test_single();
        int c0;
        ev_t e, o;
        do_reset();
        c0 = cyc;
        set_rx(2, 8'h41);
        expect_word(8'h02, c0 + 2);
        expect_word(8'h41, c0 + 3);
        tick(1);
        rx_valid = '0;
        tick(10);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL single_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o.data !== e.data || o.cyc != e.cyc) begin
                tests_failed++;
                $display("FAIL single_word: got %02h at cycle +%0d, required %02h at cycle +%0d",
                         o.data, o.cyc - c0, e.data, e.cyc - c0);
            end
        end
        tests_run++;
        if (ov_q.size() != 0) begin
            tests_failed++;
            $display("FAIL single_overrun: got %0d pulses, required 0", ov_q.size());
        end
    endtask

    task automatic test_simultaneous();
        int c0;
        ev_t e, o;
        do_reset();
        c0 = cyc;
        set_rx(0, 8'h10);
        set_rx(1, 8'h11);
        set_rx(3, 8'h13);
        expect_word(8'h00, c0 + 2);
        expect_word(8'h10, c0 + 3);
        expect_word(8'h01, c0 + 5);
        expect_word(8'h11, c0 + 6);
        expect_word(8'h03, c0 + 8);
        expect_word(8'h13, c0 + 9);
        tick(1);
        rx_valid = '0;
        tick(14);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL simul_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o.data !== e.data || o.cyc != e.cyc) begin
                tests_failed++;
                $display("FAIL simul_word: got %02h at cycle +%0d, required %02h at cycle +%0d",
                         o.data, o.cyc - c0, e.data, e.cyc - c0);
            end
        end
        tests_run++;
        if (ov_q.size() != 0) begin
            tests_failed++;
            $display("FAIL simul_overrun: got %0d pulses, required 0", ov_q.size());
        end
    endtask

    task automatic test_backpressure();
        int c0;
        ev_t e, o;
        do_reset();
        c0 = cyc;
        set_rx(1, 8'h21);
        tick(1);
        rx_valid = '0;
        tick(1);
        fifo_full = 1'b1;          // FSM is in SEND_INDEX here
        tick(2);
        set_rx(0, 8'h20);          // arrives mid-stall, must not split the pair
        tick(1);
        rx_valid = '0;
        tick(7);
        fifo_full = 1'b0;          // c0+12
        expect_word(8'h01, c0 + 12);
        expect_word(8'h21, c0 + 13);
        expect_word(8'h00, c0 + 15);
        expect_word(8'h20, c0 + 16);
        tick(10);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o.data !== e.data || o.cyc != e.cyc) begin
                tests_failed++;
                $display("FAIL bp_word: got %02h at cycle +%0d, required %02h at cycle +%0d",
                         o.data, o.cyc - c0, e.data, e.cyc - c0);
            end
        end
    endtask

    task automatic test_overrun();
        int c0;
        ev_t e, o;
        ov_t v;
        do_reset();
        c0 = cyc;
        fifo_full = 1'b1;
        set_rx(0, 8'h30);          // granted at c0+1, then stuck in SEND_INDEX
        tick(1);
        rx_valid = '0;
        tick(1);
        set_rx(1, 8'h55);          // c0+2: captured, stays pending
        tick(1);
        rx_valid = '0;
        tick(1);
        set_rx(1, 8'h66);          // c0+4: dropped
        tick(1);
        rx_valid = '0;
        tick(5);
        fifo_full = 1'b0;          // c0+10
        expect_word(8'h00, c0 + 10);
        expect_word(8'h30, c0 + 11);
        expect_word(8'h01, c0 + 13);
        expect_word(8'h55, c0 + 14);
        tick(10);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL ovr_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o.data !== e.data || o.cyc != e.cyc) begin
                tests_failed++;
                $display("FAIL ovr_word: got %02h at cycle +%0d, required %02h at cycle +%0d",
                         o.data, o.cyc - c0, e.data, e.cyc - c0);
            end
        end
        tests_run++;
        if (ov_q.size() != 1) begin
            tests_failed++;
            $display("FAIL ovr_pulses: got %0d pulses, required 1", ov_q.size());
        end else begin
            v = ov_q.pop_front();
            tests_run++;
            if (v.mask !== 4'b0010 || v.cyc != c0 + 5) begin
                tests_failed++;
                $display("FAIL ovr_pulse: got mask %b at cycle +%0d, required 0010 at cycle +5",
                         v.mask, v.cyc - c0);
            end
        end
    endtask

    task automatic test_release_collision();
        int c0;
        ev_t e, o;
        do_reset();
        c0 = cyc;
        set_rx(0, 8'h99);
        tick(1);
        set_rx(0, 8'hAA);          // c0+1: same cycle channel 0 is granted
        tick(1);
        rx_valid = '0;
        expect_word(8'h00, c0 + 2);
        expect_word(8'h99, c0 + 3);
        expect_word(8'h00, c0 + 5);
        expect_word(8'hAA, c0 + 6);
        tick(10);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL coll_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o.data !== e.data || o.cyc != e.cyc) begin
                tests_failed++;
                $display("FAIL coll_word: got %02h at cycle +%0d, required %02h at cycle +%0d",
                         o.data, o.cyc - c0, e.data, e.cyc - c0);
            end
        end
        tests_run++;
        if (ov_q.size() != 0) begin
            tests_failed++;
            $display("FAIL coll_overrun: got %0d pulses, required 0", ov_q.size());
        end
    endtask

    task automatic test_reset_mid_record();
        int c0, c1;
        ev_t e, o;
        do_reset();
        c0 = cyc;
        set_rx(1, 8'h44);
        set_rx(2, 8'h5A);          // left pending, must be discarded by reset
        tick(1);
        rx_valid = '0;
        expect_word(8'h01, c0 + 2);
        tick(2);
        fifo_full = 1'b1;          // c0+3: hold in SEND_DATA
        tick(1);
        reset = 1'b1;              // c0+4
        tick(1);
        reset     = 1'b0;          // c0+5
        fifo_full = 1'b0;
        @(negedge clk);
        tests_run++;
        if (fifo_write !== 1'b0 || fifo_data !== '0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: write=%0b data=%02h required 0/00", fifo_write, fifo_data);
        end
        tick(6);
        c1 = cyc;
        set_rx(3, 8'h7E);
        expect_word(8'h03, c1 + 2);
        expect_word(8'h7E, c1 + 3);
        tick(1);
        rx_valid = '0;
        tick(10);
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL midrst_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            tests_run++;
            if (o.data !== e.data || o.cyc != e.cyc) begin
                tests_failed++;
                $display("FAIL midrst_word: got %02h at cycle +%0d, required %02h at cycle +%0d",
                         o.data, o.cyc - c0, e.data, e.cyc - c0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        rx_valid  = '0;
        rx_data   = '0;
        fifo_full = 1'b0;
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_overrun();
        test_release_collision();
        test_reset_mid_record();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_in_mux.md
# uart_in_mux

UART-to-USB merge block: collects received bytes from `UART_COUNT` UART receivers and serialises them into the single USB-bound FIFO. Each byte is written as a two-byte record: the channel index, then the data byte. This is the same framing the USB-to-UART demultiplexer consumes on the opposite path. Each channel has a one-deep holding slot. A round-robin arbiter picks among pending slots, and per-channel overrun pulses flag any dropped bytes.

## Interface
- `DATA_BITS`, 8, width of UART data and FIFO word.
- `UART_COUNT`, 4, number of receiver channels; must satisfy 1 ≤ UART_COUNT ≤ 2**DATA_BITS.
- `clk` input 1 — clock.
- `reset` input 1 — synchronous, active-high reset.
- `rx_valid` input UART_COUNT — bit i is a one-cycle strobe: channel i received a byte.
- `rx_data` input UART_COUNT*DATA_BITS — channel i byte at `[i*DATA_BITS +: DATA_BITS]`, valid with `rx_valid[i]`.
- `fifo_full` input 1 — USB FIFO cannot accept a write this cycle.
- `fifo_write` output 1 — write enable to USB FIFO.
- `fifo_data` output DATA_BITS — word written when `fifo_write` = 1.
- `overrun` output UART_COUNT — bit i pulses one cycle when a channel i byte is dropped.

## Operation
- Per-channel slot: `pending[i]`, `hold[i]`.
  - `rx_valid[i]` with slot free, or with the slot being released this cycle: capture `rx_data` slice and set pending. No overrun.
  - `rx_valid[i]` with the slot pending and not released: the new byte is dropped, the held byte is kept, and `overrun[i]` = 1 next cycle (registered).
- FSM states: IDLE, SEND_INDEX, SEND_DATA.
- IDLE:
  - If any slot is pending, grant the first pending channel searching upward from `last+1` (wrapping modulo UART_COUNT).
  - On grant: latch channel number into `cur_idx` and `hold` into `cur_data`, clear that slot's pending, set `last` to the granted channel, go to SEND_INDEX.
  - Otherwise stay in IDLE.
- SEND_INDEX: if `~fifo_full`, write `cur_idx` zero-extended to DATA_BITS and go to SEND_DATA; else hold.
- SEND_DATA: if `~fifo_full`, write `cur_data` and go to IDLE; else hold.
- `fifo_write` = (state is SEND_INDEX or SEND_DATA) & ~fifo_full. It is never asserted while `fifo_full` = 1.
- `fifo_data` is muxed from the registered `cur_idx`/`cur_data` by state. It is 0 in IDLE.
- `last` resets to UART_COUNT-1, so channel 0 has first priority after reset.
- Index and data bytes of one record are always adjacent in the FIFO. Another channel is never granted between them.

## Timing
- Reset values: `fifo_write` 0, `fifo_data` 0, `overrun` all 0, every `pending` 0, state IDLE, `last` UART_COUNT-1.
- Latency from `rx_valid` (cycle 0) to first write is 2 cycles with no backpressure:
  - cycle 1: grant in IDLE.
  - cycle 2: index byte written.
  - cycle 3: data byte written.
- Throughput is at most one record per 3 cycles, so aggregate rx rate must stay below this.
- `fifo_full` stalls the FSM in place. Stall duration is unbounded. Slots keep capturing during a stall, and overruns fire as specified.
- Simultaneous grant of channel i and `rx_valid[i]` in IDLE: the new byte is captured into the freed slot with no overrun. It is sent after the current record (next eligible round-robin turn).
- Reset mid-operation aborts the record. A written index byte may be left without its data byte; the USB-side parser resynchronises on reset. Held bytes are discarded.

## Structure
- Package `uart_mux_pkg`: state encoding constants (IDLE=0, SEND_INDEX=1, SEND_DATA=2) and a clog2 helper for `cur_idx`/`last` width. The package is shared with the USB-to-UART demux.
- Sub-module `uart_in_slot`: one-deep holding register with capture, release and overrun logic, instantiated UART_COUNT times.
- The round-robin arbiter and FSM live in the top level.

## Test plan
- Single byte: `rx_valid[2]`, data 0x41 at cycle 0 → `fifo_write` at cycles 2–3 with `fifo_data` 0x02 then 0x41; `overrun` stays 0.
- Simultaneous channels: `rx_valid` = 4'b1011 with data 0x10/0x11/–/0x13 in the same cycle → FIFO stream 00 10 01 11 03 13; writes at cycles 2,3 / 5,6 / 8,9.
- Backpressure: `fifo_full` = 1 for 10 cycles starting during SEND_INDEX → no write while full; index and data written on consecutive non-full cycles afterward; the pair is not split by another channel.
- Overrun: channel 1 receives 0x55, then 0x66 while pending and blocked by `fifo_full` → `overrun[1]` pulses once; FIFO later receives 01 55 only.
- Release collision: `rx_valid[0]` with 0xAA on the grant cycle of a pending 0x99 on channel 0 → stream 00 99 00 AA; no overrun.
- Reset mid-record: assert `reset` in SEND_DATA → next cycle `fifo_write` 0, all pending cleared; next rx on channel 3 (0x7E) → stream 03 7E.
